// File: rtl/z80_bus_responder.sv
// Target side of the Z80/tv80s external bus: decodes memory, I/O, INTA and refresh
// cycles, stretches them with wait_n and forwards real accesses to a req/ack backend.
module z80_bus_responder #(
    parameter logic [7:0] IO_PAGE   = 8'h10,
    parameter int         M1_WAIT   = 0,
    parameter int         MEM_WAIT  = 0,
    parameter int         IO_WAIT   = 0,
    parameter logic [7:0] IM_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        STRETCH = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] M1_LIM  = 8'(M1_WAIT);
    localparam logic [7:0] MEM_LIM = 8'(MEM_WAIT);
    localparam logic [7:0] IO_LIM  = 8'(IO_WAIT);

    state_t     state;
    logic       armed;
    logic [7:0] wait_cnt;
    logic [7:0] wait_lim;
    logic       is_io;
    logic       is_read;

    logic strobe;
    logic mem_hit;
    logic io_hit;
    logic inta_hit;
    logic hit;
    logic bus_idle;
    logic still_active;
    logic [7:0] cnt_inc;

    always_comb begin
        strobe       = !rd_n || !wr_n;
        mem_hit      = !mreq_n && rfsh_n && strobe;
        io_hit       = !iorq_n && m1_n && strobe;
        inta_hit     = !iorq_n && !m1_n;
        hit          = armed && (mem_hit || io_hit || inta_hit);
        bus_idle     = mreq_n && iorq_n;
        // A cycle whose strobes vanish while the backend is busy is treated as aborted.
        still_active = strobe && (is_io ? !iorq_n : !mreq_n);
        cnt_inc      = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        wait_n       = !(hit || state == REQ || state == STRETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b1;
            cpu_di    <= 8'hFF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            wait_cnt  <= 8'd0;
            wait_lim  <= 8'd0;
            is_io     <= 1'b0;
            is_read   <= 1'b0;
        end else begin
            if (state == IDLE && hit) begin
                armed <= 1'b0;
            end else if (bus_idle) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hit) begin
                        wait_cnt <= 8'd0;
                        if (inta_hit) begin
                            state    <= STRETCH;
                            cpu_di   <= IM_VECTOR;
                            wait_lim <= 8'd0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= !wr_n;
                            mem_wdata <= cpu_dout;
                            is_io     <= io_hit;
                            is_read   <= !rd_n;
                            mem_addr  <= io_hit ? {IO_PAGE, A[7:0]} : A;
                            wait_lim  <= io_hit ? IO_LIM : (!m1_n ? M1_LIM : MEM_LIM);
                        end
                    end
                end
                REQ: begin
                    wait_cnt <= cnt_inc;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (is_read) begin
                            cpu_di <= mem_rdata;
                        end
                        // Skip STRETCH entirely when the minimum wait is already covered.
                        if (!still_active) begin
                            state <= IDLE;
                        end else if (cnt_inc >= wait_lim) begin
                            state <= DONE;
                        end else begin
                            state <= STRETCH;
                        end
                    end
                end
                STRETCH: begin
                    wait_cnt <= cnt_inc;
                    if (cnt_inc >= wait_lim) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus_idle) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: memory/I/O/INTA/refresh cycles, M1 wait
// stretching, bus abort and reset during an outstanding request.
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_di;
    logic        wait_n;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    logic req_q = 1'b0;

    always #5 clk = ~clk;

    z80_bus_responder #(.M1_WAIT(2)) u_dut (
        .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A),
        .cpu_dout(cpu_dout), .cpu_di(cpu_di), .wait_n(wait_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always @(posedge clk) begin
        if (mem_req && !req_q) req_rises <= req_rises + 1;
        req_q <= mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; bus_idle(); A = 16'h0000; cpu_dout = 8'h00;
        mem_rdata = 8'h00; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_wait_n", 16'(wait_n), 16'h1);
        check("rst_mem_req", 16'(mem_req), 16'h0);
        check("rst_cpu_di", 16'(cpu_di), 16'h00FF);
        check("rst_mem_addr", mem_addr, 16'h0000);

        // Memory read at 0000, ack three cycles into REQ
        A = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0; #1;
        check("rd_hit_wait", 16'(wait_n), 16'h0);
        check("rd_no_req_yet", 16'(mem_req), 16'h0);
        tick();
        check("rd_req", 16'(mem_req), 16'h1);
        check("rd_addr", mem_addr, 16'h0000);
        check("rd_we", 16'(mem_we), 16'h0);
        tick(); tick();
        check("rd_wait_held", 16'(wait_n), 16'h0);
        mem_ack = 1'b1; mem_rdata = 8'hED;
        tick();
        mem_ack = 1'b0;
        check("rd_req_drop", 16'(mem_req), 16'h0);
        check("rd_cpu_di", 16'(cpu_di), 16'h00ED);
        check("rd_wait_rel", 16'(wait_n), 16'h1);
        tick(); tick();
        check("rd_single_req", 16'(req_rises), 16'd1);
        bus_idle(); tick();

        // I/O write to port 7C, data 2D
        A = 16'hAB7C; cpu_dout = 8'h2D; iorq_n = 1'b0; wr_n = 1'b0; #1;
        check("io_hit_wait", 16'(wait_n), 16'h0);
        tick();
        check("io_addr", mem_addr, 16'h107C);
        check("io_we", 16'(mem_we), 16'h1);
        check("io_wdata", 16'(mem_wdata), 16'h002D);
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        check("io_wait_rel", 16'(wait_n), 16'h1);
        check("io_cpu_di_kept", 16'(cpu_di), 16'h00ED);
        bus_idle(); tick();

        // Interrupt acknowledge
        m1_n = 1'b0; iorq_n = 1'b0; #1;
        check("inta_wait", 16'(wait_n), 16'h0);
        tick();
        check("inta_vector", 16'(cpu_di), 16'h00FF);
        tick();
        check("inta_wait_rel", 16'(wait_n), 16'h1);
        bus_idle(); tick();
        check("inta_no_req", 16'(req_rises), 16'd2);

        // Refresh cycle never hits
        mreq_n = 1'b0; rfsh_n = 1'b0; A = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rfsh_wait", 16'(wait_n), 16'h1);
            check("rfsh_req", 16'(mem_req), 16'h0);
        end
        bus_idle(); tick();

        // Opcode fetch with M1_WAIT=2, ack in first REQ cycle
        A = 16'h1234; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; #1;
        check("m1_wait_c1", 16'(wait_n), 16'h0);
        tick();
        check("m1_addr", mem_addr, 16'h1234);
        check("m1_wait_c2", 16'(wait_n), 16'h0);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        check("m1_wait_c3", 16'(wait_n), 16'h0);
        check("m1_cpu_di", 16'(cpu_di), 16'h003C);
        tick();
        check("m1_wait_rel", 16'(wait_n), 16'h1);
        bus_idle(); tick();

        // Bus abort: strobes withdrawn while REQ outstanding
        A = 16'h0042; mreq_n = 1'b0; rd_n = 1'b0;
        tick();
        check("ab_req", 16'(mem_req), 16'h1);
        bus_idle();
        tick();
        check("ab_wait_held", 16'(wait_n), 16'h0);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        check("ab_cpu_di", 16'(cpu_di), 16'h0077);
        check("ab_wait_rel", 16'(wait_n), 16'h1);
        check("ab_req_drop", 16'(mem_req), 16'h0);

        // Reset during REQ, late ack must be ignored
        A = 16'h5555; mreq_n = 1'b0; rd_n = 1'b0;
        tick();
        check("rr_req", 16'(mem_req), 16'h1);
        reset = 1'b1; bus_idle();
        tick();
        check("rr_req_drop", 16'(mem_req), 16'h0);
        check("rr_wait", 16'(wait_n), 16'h1);
        check("rr_cpu_di", 16'(cpu_di), 16'h00FF);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        tick();
        mem_ack = 1'b0;
        tick();
        check("rr_ack_ign_di", 16'(cpu_di), 16'h00FF);
        check("rr_ack_ign_req", 16'(mem_req), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
